focal_row_stream: RTL and testbench
===================================

Name: focal_row_stream

Overview:
- Streaming 1-D focal (neighbourhood) filter over raster rows.
- Each input pixel produces one output pixel: the max or min of its window [x-R, x+R], with the window clipped at row edges.
- Generalises the fixed 4-pixel row-max unit to parametrised pixel width and window radius, adds a min mode, valid/ready handshakes, and end-of-row flush.
- Sits between the pixel input deserialiser and the raster op output mux.

Parameters:
- W, 4, pixel width in bits (1..8).
- R, 1, window radius in pixels (1..3); window holds 2R+1 entries.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort: drop row, clear window and output, go to IDLE.
- mode  in  1  0 = max, 1 = min; sampled only when a row's first pixel is accepted.
- in_data  in  W  input pixel.
- in_valid  in  1  input pixel valid.
- in_last  in  1  marks the last pixel of the row; qualified by in_valid.
- in_ready  out  1  block can accept a pixel this cycle.
- out_data  out  W  filtered pixel.
- out_valid  out  1  out_data valid.
- out_last  out  1  marks the last output of the row.
- out_ready  in  1  downstream accepts output.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, all window entries invalid, mode_q=0, flush_cnt=0.
  - out_data=0, out_valid=0, out_last=0.
- Window:
  - Shift register win[0..2R] of {valid, pixel}; win[0] is newest.
  - Centre entry is win[R].
- Output slot:
  - slot_free = !out_valid | out_ready.
  - in_ready = slot_free & (state != FLUSH).
- Advance event:
  - RUN/IDLE: in_valid & in_ready. Shifts {1, in_data} into win[0].
  - FLUSH: slot_free. Shifts {0, x} into win[0].
- Emit rule, evaluated on the post-shift window:
  - If the new win[R] is valid: out_data <= reduction, out_valid <= 1.
  - Reduction = max (mode_q=0) or min (mode_q=1) over valid entries only. Invalid entries are ignored (equivalent to 0 for max, all-ones for min).
  - Otherwise, out_valid <= 0 if out_ready.
- Registered output:
  - out_data/out_last hold stable while out_valid & !out_ready.
  - Output is cleared after acceptance when no new emit occurs.
- States:
  - IDLE: first accepted pixel latches mode_q and goes to RUN. If in_last is also set, go directly to FLUSH.
  - RUN: accepted pixel with in_last goes to FLUSH with flush_cnt=0.
  - FLUSH: in_ready=0. Each advance increments flush_cnt. On the advance with flush_cnt==R-1: out_last <= 1 with that emit, all window entries are invalidated, and state goes to IDLE.
- Flush length is exactly R advances for every row length, including rows shorter than R+1.
- Output count equals the input count per row; the final output always carries out_last=1.
- Latency (out_ready held 1): the output for pixel j is valid in the cycle after pixel j+R is accepted. For the last R pixels, outputs appear on consecutive flush cycles.
- Back-to-back rows: the next row's first pixel is accepted in the cycle after the final flush advance. Windows never mix rows.
- Backpressure: out_ready=0 with out_valid=1 forces in_ready=0 and stalls the flush. No pixel is lost or duplicated.
- clr:
  - Takes priority over all events in the same cycle.
  - Outputs and window go to reset values; state goes to IDLE.
  - A pending output is discarded.
- in_last is ignored unless the pixel is accepted. in_data is don't-care when in_valid=0.
- Widths: comparisons are unsigned W-bit. There is no arithmetic growth.

Test Plan:
1. R=1, mode=0, continuous ready. Row 3,7,2,9,1 (last on 1) -> outputs 7,7,9,9,9. out_last only on the 5th output. in_ready=0 for exactly 1 cycle.
2. R=1, mode=1, same row -> outputs 3,2,2,1,1. Changing mode mid-row has no effect until the next row.
3. R=2, mode=0. Row 1,2,3 (last) -> 3,3,3. Single-pixel row 5 (last) -> single output 5 with out_last after 2 flush cycles. No output during fill.
4. R=1. Row 9,9 (last) then immediately row 1,2 (last) -> 9,9 then 2,2. The first output of row 2 is not 9.
5. Row 3,7,2,9,1 with out_ready=0 for 3 cycles while out_valid=1 -> out_data stable, in_ready=0, final sequence unchanged (7,7,9,9,9).
6. Mid-row (after 3,7 accepted): assert rst_n=0 asynchronously (then repeat the scenario with clr=1) -> outputs 0/invalid immediately, state IDLE. Next row 4 (last) -> single output 4 with out_last.

Source files
------------

// File: rtl/focal_row_stream.sv
// Streaming 1-D max/min focal filter over raster rows with a clipped (2R+1)-pixel window,
// valid/ready handshakes on both sides and an R-advance flush at the end of each row.
module focal_row_stream #(
   parameter int W = 4,
   parameter int R = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         mode,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   output logic         out_last,
   input  logic         out_ready
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t                state_q;
   logic [2*R:0]          win_vld_q, win_vld_d;
   logic [2*R:0][W-1:0]   win_pix_q, win_pix_d;
   logic                  mode_q;
   logic [1:0]            flush_cnt_q;
   logic [W-1:0]          out_data_q;
   logic                  out_valid_q, out_last_q;

   logic                  slot_free, accept, flush_adv, advance, final_adv, emit;
   logic [W-1:0]          red_d;

   // Invalid entries start the accumulator at the identity value, so they never win.
   function automatic logic [W-1:0] reduce(input logic [2*R:0] vld,
                                           input logic [2*R:0][W-1:0] pix,
                                           input logic use_min);
      logic [W-1:0] acc;
      acc = use_min ? {W{1'b1}} : {W{1'b0}};
      for (int i = 0; i <= 2*R; i++) begin
         if (vld[i] && (use_min ? (pix[i] < acc) : (pix[i] > acc)))
            acc = pix[i];
      end
      return acc;
   endfunction

   always_comb begin
      slot_free = !out_valid_q || out_ready;
      in_ready  = slot_free && (state_q != FLUSH);
      accept    = in_valid && in_ready;
      flush_adv = (state_q == FLUSH) && slot_free;
      advance   = accept || flush_adv;
      final_adv = flush_adv && (flush_cnt_q == 2'(R-1));
      win_vld_d = {win_vld_q[2*R-1:0], accept};
      win_pix_d = {win_pix_q[2*R-1:0], in_data};
      emit      = advance && win_vld_d[R];
      red_d     = reduce(win_vld_d, win_pix_d, mode_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         win_vld_q   <= '0;
         win_pix_q   <= '0;
         mode_q      <= 1'b0;
         flush_cnt_q <= 2'd0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else if (clr) begin
         state_q     <= IDLE;
         win_vld_q   <= '0;
         win_pix_q   <= '0;
         mode_q      <= 1'b0;
         flush_cnt_q <= 2'd0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         // The final flush advance drops the whole window so the next row starts clean.
         if (advance) begin
            win_vld_q <= final_adv ? '0 : win_vld_d;
            win_pix_q <= win_pix_d;
         end

         if (emit) begin
            out_data_q  <= red_d;
            out_valid_q <= 1'b1;
            out_last_q  <= final_adv;
         end else if (out_ready) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (accept) begin
                  mode_q      <= mode;
                  flush_cnt_q <= 2'd0;
                  state_q     <= in_last ? FLUSH : RUN;
               end
            end
            RUN: begin
               if (accept && in_last) begin
                  flush_cnt_q <= 2'd0;
                  state_q     <= FLUSH;
               end
            end
            FLUSH: begin
               if (flush_adv) begin
                  if (final_adv) begin
                     flush_cnt_q <= 2'd0;
                     state_q     <= IDLE;
                  end else begin
                     flush_cnt_q <= flush_cnt_q + 2'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_focal_row_stream.sv
// Bench for focal_row_stream: R=1 and R=2 instances, table-driven rows, reset/clear
// sequences and randomized rows scored against a clipped-window max/min model.
module tb_focal_row_stream;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       mode;
   logic [3:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       out_ready;
   logic       sel;

   logic       r1_in_ready, r1_out_valid, r1_out_last;
   logic [3:0] r1_out_data;
   logic       r2_in_ready, r2_out_valid, r2_out_last;
   logic [3:0] r2_out_data;

   logic       obs_in_ready, obs_out_valid, obs_out_last;
   logic [3:0] obs_out_data;

   always #5 clk = ~clk;

   focal_row_stream #(.W(4), .R(1)) u_r1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode),
      .in_data(in_data), .in_valid(in_valid & ~sel), .in_last(in_last),
      .in_ready(r1_in_ready), .out_data(r1_out_data), .out_valid(r1_out_valid),
      .out_last(r1_out_last), .out_ready(out_ready));

   focal_row_stream #(.W(4), .R(2)) u_r2 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode),
      .in_data(in_data), .in_valid(in_valid & sel), .in_last(in_last),
      .in_ready(r2_in_ready), .out_data(r2_out_data), .out_valid(r2_out_valid),
      .out_last(r2_out_last), .out_ready(out_ready));

   assign obs_in_ready  = sel ? r2_in_ready  : r1_in_ready;
   assign obs_out_valid = sel ? r2_out_valid : r1_out_valid;
   assign obs_out_data  = sel ? r2_out_data  : r1_out_data;
   assign obs_out_last  = sel ? r2_out_last  : r1_out_last;

   int passed = 0;
   int total  = 0;

   logic [3:0] row   [64];
   logic [3:0] exp_d [64];
   logic [3:0] got_d [64];
   logic       got_l [64];
   int         acc_cyc [64];
   int         out_cyc [64];
   int         got_n;

   typedef struct {
      int          r;
      logic        m;
      int          n;
      logic [31:0] px;
      logic [31:0] ex;
      int          stall;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
   endtask

   // Output j is the max/min of the row pixels j-r..j+r that actually exist.
   function automatic logic [3:0] model(input int j, input int n, input int r, input logic m);
      logic [3:0] q [$];
      for (int k = j - r; k <= j + r; k++)
         if (k >= 0 && k < n) q.push_back(row[k]);
      if (m) begin
         q.sort();
      end else begin
         q.rsort();
      end
      return q[0];
   endfunction

   // Entered and left at a falling edge; inputs change there, handshakes are sampled 1ns later.
   task automatic run_row(input string tag, input int n, input logic m,
                          input bit rv, input bit rr, input int stall);
      int         idx = 0;
      int         cyc = 0;
      int         nrdy = 0;
      int         stall_left = stall;
      int         r = sel ? 2 : 1;
      logic [3:0] held = 4'd0;
      bit         stalled;
      got_n = 0;
      while ((idx < n || got_n < n) && cyc < 400) begin
         in_valid = (idx < n) && (!rv || $urandom_range(3) != 0);
         in_data  = in_valid ? row[idx] : 4'($urandom);
         in_last  = (idx == n - 1);
         mode     = (idx == 0) ? m : ~m;
         stalled  = (stall_left > 0) && obs_out_valid;
         out_ready = stalled ? 1'b0 : (!rr || $urandom_range(3) != 0);
         #1;
         if (!obs_in_ready) nrdy++;
         if (stalled) begin
            if (stall_left == stall) held = obs_out_data;
            else chk({tag, " stall data"}, obs_out_data, held);
            chk({tag, " stall in_ready"}, obs_in_ready, 0);
            stall_left--;
         end
         if (in_valid && obs_in_ready) begin
            acc_cyc[idx] = cyc;
            idx++;
         end
         if (obs_out_valid && out_ready && got_n < 64) begin
            got_d[got_n]   = obs_out_data;
            got_l[got_n]   = obs_out_last;
            out_cyc[got_n] = cyc;
            got_n++;
            if (got_n == n) chk({tag, " ready after last"}, obs_in_ready, 1);
         end
         @(negedge clk);
         cyc++;
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      if (cyc >= 400) chk({tag, " timeout"}, cyc, 0);
      if (!rv && !rr && stall == 0) begin
         chk({tag, " in_ready low cycles"}, nrdy, r);
         if (n > r) chk({tag, " latency"}, out_cyc[0], acc_cyc[r] + 1);
      end
   endtask

   task automatic cmp_row(input string tag, input int n);
      chk({tag, " count"}, got_n, n);
      for (int j = 0; j < n && j < got_n; j++) begin
         chk($sformatf("%s data[%0d]", tag, j), got_d[j], exp_d[j]);
         chk($sformatf("%s last[%0d]", tag, j), got_l[j], (j == n - 1) ? 1 : 0);
      end
   endtask

   task automatic feed(input logic [3:0] d);
      in_valid  = 1'b1;
      in_data   = d;
      in_last   = 1'b0;
      mode      = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("feed accept", obs_in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; mode = 1'b0; in_data = 4'd0;
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; sel = 1'b0;

      tbl[0] = '{1, 1'b0, 5, 32'h37291,  32'h77999,  0};
      tbl[1] = '{1, 1'b1, 5, 32'h37291,  32'h32211,  0};
      tbl[2] = '{2, 1'b0, 3, 32'h123,    32'h333,    0};
      tbl[3] = '{2, 1'b0, 1, 32'h5,      32'h5,      0};
      tbl[4] = '{1, 1'b0, 2, 32'h99,     32'h99,     0};
      tbl[5] = '{1, 1'b0, 2, 32'h12,     32'h22,     0};
      tbl[6] = '{1, 1'b0, 5, 32'h37291,  32'h77999,  3};
      tbl[7] = '{2, 1'b1, 6, 32'h836974, 32'h333344, 0};
      tbl[8] = '{1, 1'b0, 1, 32'hF,      32'hF,      0};
      tbl[9] = '{1, 1'b1, 3, 32'h0FF,    32'h00F,    0};

      repeat (3) @(negedge clk);
      #1;
      chk("reset r1 out_valid", r1_out_valid, 0);
      chk("reset r1 out_data", r1_out_data, 0);
      chk("reset r2 out_last", r2_out_last, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post-reset in_ready", r1_in_ready, 1);
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         sel = (tbl[i].r == 2);
         for (int k = 0; k < tbl[i].n; k++) begin
            row[k]   = tbl[i].px[4*(tbl[i].n-1-k) +: 4];
            exp_d[k] = tbl[i].ex[4*(tbl[i].n-1-k) +: 4];
         end
         run_row($sformatf("vec%0d", i), tbl[i].n, tbl[i].m, 1'b0, 1'b0, tbl[i].stall);
         cmp_row($sformatf("vec%0d", i), tbl[i].n);
      end
      repeat (2) begin
         #1;
         chk("idle no extra output", obs_out_valid, 0);
         @(negedge clk);
      end

      // Asynchronous reset in the middle of a row.
      sel = 1'b0;
      feed(4'd3);
      feed(4'd7);
      #1;
      chk("pre-reset out_valid", r1_out_valid, 1);
      chk("pre-reset out_data", r1_out_data, 7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset out_valid", r1_out_valid, 0);
      chk("async reset out_data", r1_out_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      row[0] = 4'd4; exp_d[0] = 4'd4;
      run_row("after reset", 1, 1'b0, 1'b0, 1'b0, 0);
      cmp_row("after reset", 1);

      // Synchronous clear with an output pending under backpressure.
      feed(4'd3);
      feed(4'd7);
      out_ready = 1'b0;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      #1;
      chk("clr out_valid", r1_out_valid, 0);
      chk("clr out_data", r1_out_data, 0);
      chk("clr in_ready", r1_in_ready, 1);
      @(negedge clk);
      out_ready = 1'b1;
      row[0] = 4'd4; exp_d[0] = 4'd4;
      run_row("after clr", 1, 1'b0, 1'b0, 1'b0, 0);
      cmp_row("after clr", 1);

      for (int t = 0; t < 40; t++) begin
         int   n;
         int   r;
         logic m;
         sel = 1'($urandom_range(1));
         r   = sel ? 2 : 1;
         n   = $urandom_range(1, 8);
         m   = 1'($urandom_range(1));
         for (int k = 0; k < n; k++) row[k] = 4'($urandom);
         for (int k = 0; k < n; k++) exp_d[k] = model(k, n, r, m);
         run_row($sformatf("rnd%0d", t), n, m, 1'b1, 1'b1, 0);
         cmp_row($sformatf("rnd%0d", t), n);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
